// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART TX controller: register window decode, byte FIFO, launch sequencer.
// BAUD/CFG writes land in shadows and reach the transmitter only while idle with an empty FIFO.
module uart_tx_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_01B8,
    parameter logic [15:0] BAUD_RST  = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    output logic [31:0] rdata,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [15:0] baud_div,
    output logic [7:0]  cfg
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [7:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic         r_ovf;

    logic [15:0]  r_baud_sh;
    logic [7:0]   r_cfg_sh;
    logic         r_baud_pend;
    logic         r_cfg_pend;
    logic [15:0]  r_baud_div;
    logic [7:0]   r_cfg;
    logic [7:0]   r_tx_data;

    logic [29:0]  w_word_off;
    logic         w_in_win;
    logic         w_wr_baud;
    logic         w_wr_cfg;
    logic         w_wr_data;
    logic         w_wr_status;
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_push;
    logic         w_drop;
    logic         w_safe;
    logic [31:0]  w_status;
    logic         w_unused;

    // Word offset from the window base; byte lane bits are ignored.
    assign w_word_off  = addr[31:2] - BASE_ADDR[31:2];
    assign w_in_win    = (w_word_off < 30'd4);
    assign w_wr_baud   = wr_en && w_in_win && (w_word_off[1:0] == 2'd0);
    assign w_wr_cfg    = wr_en && w_in_win && (w_word_off[1:0] == 2'd1);
    assign w_wr_data   = wr_en && w_in_win && (w_word_off[1:0] == 2'd2);
    assign w_wr_status = wr_en && w_in_win && (w_word_off[1:0] == 2'd3);

    assign w_unused    = ^{addr[1:0], wdata[31:16]};

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = (r_state == S_LAUNCH);
    assign w_push  = w_wr_data && (!w_full || w_pop);
    assign w_drop  = w_wr_data && w_full && !w_pop;
    assign w_safe  = (r_state == S_IDLE) && w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            // A drop in the same cycle as a W1C keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && wdata[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // A write arriving while already safe goes straight through, so the
    // active value follows one edge after the store like the shadow does.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_sh   <= BAUD_RST;
            r_cfg_sh    <= 8'd0;
            r_baud_pend <= 1'b0;
            r_cfg_pend  <= 1'b0;
            r_baud_div  <= BAUD_RST;
            r_cfg       <= 8'd0;
        end else begin
            if (w_wr_baud) begin
                r_baud_sh <= wdata[15:0];
                if (w_safe) begin
                    r_baud_div  <= wdata[15:0];
                    r_baud_pend <= 1'b0;
                end else begin
                    r_baud_pend <= 1'b1;
                end
            end else if (r_baud_pend && w_safe) begin
                r_baud_div  <= r_baud_sh;
                r_baud_pend <= 1'b0;
            end

            if (w_wr_cfg) begin
                r_cfg_sh <= wdata[7:0];
                if (w_safe) begin
                    r_cfg      <= wdata[7:0];
                    r_cfg_pend <= 1'b0;
                end else begin
                    r_cfg_pend <= 1'b1;
                end
            end else if (r_cfg_pend && w_safe) begin
                r_cfg      <= r_cfg_sh;
                r_cfg_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending shadows only matter with an empty FIFO, where no launch can occur anyway.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_cfg[0] && !w_empty && !tx_busy) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data <= 8'd0;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_LAUNCH)) begin
            r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    assign w_status = {21'd0, 7'(r_count), r_ovf, (r_state != S_IDLE), w_full, w_empty};

    always_comb begin
        rdata = 32'd0;
        if (w_in_win) begin
            case (w_word_off[1:0])
                2'd0:    rdata = {16'd0, r_baud_sh};
                2'd1:    rdata = {24'd0, r_cfg_sh};
                2'd3:    rdata = w_status;
                default: rdata = 32'd0;
            endcase
        end
    end

    assign tx_start = (r_state == S_LAUNCH);
    assign tx_data  = r_tx_data;
    assign baud_div = r_baud_div;
    assign cfg      = r_cfg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a transmitter model busy 20 cycles per frame.
module tb_uart_tx_ctrl;
    localparam logic [31:0] A_BAUD   = 32'h0000_01B8;
    localparam logic [31:0] A_CFG    = 32'h0000_01BC;
    localparam logic [31:0] A_DATA   = 32'h0000_01C0;
    localparam logic [31:0] A_STATUS = 32'h0000_01C4;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [31:0] rdata;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] baud_div;
    logic [7:0]  cfg;

    int checks   = 0;
    int failures = 0;

    int          busy_cnt   = 0;
    logic        force_busy = 1'b0;
    int          bad_launch = 0;
    logic [7:0]  launched [$];

    uart_tx_ctrl #(
        .DEPTH     (8),
        .BASE_ADDR (32'h0000_01B8),
        .BAUD_RST  (16'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .wr_en    (wr_en),
        .rdata    (rdata),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .baud_div (baud_div),
        .cfg      (cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = (busy_cnt != 0) || force_busy;

    // Transmitter model and launch monitor; busy rises the cycle after tx_start.
    always @(negedge clk) begin
        if (tx_start) begin
            if (busy_cnt != 0 || force_busy) bad_launch++;
            launched.push_back(tx_data);
        end
        if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
        if (tx_start) busy_cnt = 20;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int n, input int bound);
        int k;
        k = 0;
        addr = A_STATUS;
        #1;
        while (!(launched.size() == n && rdata == 32'h1) && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, 32'(k < bound), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp4 [9];
        int k;
        int early;

        exp4 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
        rst   = 1'b1;
        addr  = 32'd0;
        wdata = 32'd0;
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and window edges
        chk_reg("rst_status", A_STATUS, 32'h001);
        chk("rst_baud_div", 32'(baud_div), 32'h0);
        chk("rst_cfg", 32'(cfg), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk_reg("below_window", 32'h0000_01B4, 32'h0);
        chk_reg("above_window", 32'h0000_01C8, 32'h0);

        // Config writes while idle and empty apply one edge later
        bus_write(A_BAUD, 32'hDEAD_38B0);
        chk("baud_apply", 32'(baud_div), 32'h38B0);
        bus_write(A_CFG, 32'h0000_0001);
        chk("cfg_apply", 32'(cfg), 32'h01);
        chk_reg("baud_readback", A_BAUD, 32'h38B0);
        chk_reg("baud_unaligned", 32'h0000_01BA, 32'h38B0);
        chk_reg("cfg_readback", A_CFG, 32'h01);
        bus_write(32'h0000_01C8, 32'h0000_0077);
        chk_reg("outside_write_ignored", A_BAUD, 32'h38B0);

        // Three bytes in FIFO order, one launch per frame
        bus_write(A_DATA, 32'h0000_00B6);
        bus_write(A_DATA, 32'h0000_0042);
        bus_write(A_DATA, 32'h0000_0039);
        chk_reg("status_active", A_STATUS, 32'h024);
        chk_reg("data_reads_zero", A_DATA, 32'h0);
        wait_drain("drain3_timeout", 3, 200);
        chk("drain3_count", 32'(launched.size()), 32'd3);
        chk("launch0", 32'(launched[0]), 32'hB6);
        chk("launch1", 32'(launched[1]), 32'h42);
        chk("launch2", 32'(launched[2]), 32'h39);
        chk("tx_data_hold", 32'(tx_data), 32'h39);
        chk_reg("status_end3", A_STATUS, 32'h001);

        // Fill past full with the transmitter held busy
        launched.delete();
        force_busy = 1'b1;
        for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'h10 + 32'(i));
        chk_reg("status_full_ovf", A_STATUS, 32'h08A);
        bus_write(A_STATUS, 32'h0000_0000);
        chk_reg("w1c_zero_keeps", A_STATUS, 32'h08A);
        bus_write(A_STATUS, 32'h0000_0008);
        chk_reg("w1c_clears", A_STATUS, 32'h082);

        // Push while full in the pop cycle is accepted
        force_busy = 1'b0;
        @(negedge clk);
        chk("launch_pulse", 32'(tx_start), 32'h1);
        chk("launch_head", 32'(tx_data), 32'h10);
        bus_write(A_DATA, 32'h0000_0055);
        chk_reg("full_push_pop", A_STATUS, 32'h086);
        wait_drain("drain9_timeout", 9, 400);
        chk("drain9_count", 32'(launched.size()), 32'd9);
        for (int i = 0; i < 9; i++) chk("drain9_seq", 32'(launched[i]), 32'(exp4[i]));

        // Baud change deferred while bytes are queued
        launched.delete();
        force_busy = 1'b1;
        bus_write(A_DATA, 32'h0000_00A1);
        bus_write(A_DATA, 32'h0000_00A2);
        bus_write(A_BAUD, 32'h0000_0010);
        chk("baud_deferred", 32'(baud_div), 32'h38B0);
        chk_reg("baud_shadow_read", A_BAUD, 32'h0010);
        chk_reg("status_two_queued", A_STATUS, 32'h020);
        force_busy = 1'b0;
        early = 0;
        k = 0;
        addr = A_STATUS;
        #1;
        while (!(launched.size() == 2 && rdata == 32'h1) && k < 200) begin
            if (baud_div !== 16'h38B0) early++;
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain2_timeout", 32'(k < 200), 32'd1);
        chk("baud_no_early", 32'(early), 32'd0);
        chk("baud_old_at_idle", 32'(baud_div), 32'h38B0);
        @(negedge clk);
        chk("baud_new_after_idle", 32'(baud_div), 32'h0010);
        chk("drain2_seq0", 32'(launched[0]), 32'hA1);
        chk("drain2_seq1", 32'(launched[1]), 32'hA2);

        // Reset in WAIT_DONE, then stale busy must block the next launch
        bus_write(A_DATA, 32'h0000_00C1);
        bus_write(A_DATA, 32'h0000_00C2);
        k = 0;
        while (!tx_busy && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("busy_rise_timeout", 32'(k < 50), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk_reg("status_wait_done", A_STATUS, 32'h014);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        launched.delete();
        chk_reg("rst2_status", A_STATUS, 32'h001);
        chk("rst2_tx_start", 32'(tx_start), 32'h0);
        chk("rst2_tx_data", 32'(tx_data), 32'h0);
        chk("rst2_baud", 32'(baud_div), 32'h0);
        chk("rst2_cfg", 32'(cfg), 32'h0);
        bus_write(A_CFG, 32'h0000_0001);
        chk("rst2_cfg_apply", 32'(cfg), 32'h01);
        bus_write(A_DATA, 32'h0000_00D1);
        chk_reg("stale_busy_hold", A_STATUS, 32'h010);
        wait_drain("stale_drain_timeout", 1, 100);
        chk("stale_launch", 32'(launched[0]), 32'hD1);
        chk("no_launch_while_busy", 32'(bad_launch), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Memory-mapped controller between the single-cycle core's data-memory store/load path and the UART transmitter core.
- Decodes core accesses to the UART register window and buffers data bytes in a FIFO.
- Sequences byte launches into the transmitter with a start/busy handshake.
- Owns the baud divisor and config registers and applies their changes only at safe points.

Parameters:
- DEPTH, 8: TX FIFO depth in bytes; power of two, 2 to 64.
- BASE_ADDR, 32'h000001B8: byte address of the baud register. Window is BASE_ADDR+0x0 to BASE_ADDR+0xC.
- BAUD_RST, 16'd0: reset value of the baud divisor.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- addr  in  32  core data-memory byte address.
- wdata  in  32  core store data.
- wr_en  in  1  core store strobe, one cycle per store.
- rdata  out  32  read data; combinational from addr.
- tx_busy  in  1  transmitter busy (high while shifting a frame).
- tx_start  out  1  one-cycle launch pulse to the transmitter.
- tx_data  out  8  byte for the transmitter; valid while tx_start=1.
- baud_div  out  16  active divisor to the transmitter.
- cfg  out  8  active config to the transmitter. bit0 tx_en, bit1 parity_en, bit2 parity_odd, bit3 two_stop.

Behaviour:
- Register map (word-aligned; addr[1:0] ignored):
  - +0x0 BAUD, RW, [15:0].
  - +0x4 CFG, RW, [7:0].
  - +0x8 DATA, WO. A write pushes wdata[7:0]; reads return 0.
  - +0xC STATUS, RO except W1C. Bits: [0] empty, [1] full, [2] active, [3] overflow (sticky), [10:4] count.
  - Any addr outside the window: rdata=0 and writes are ignored.
- Reset:
  - FIFO empty, count=0, overflow=0, state IDLE.
  - tx_start=0, tx_data=0.
  - baud_div=BAUD_RST, cfg=0, shadow-pending flags=0.
  - Reset mid-frame aborts sequencing immediately. The transmitter is not told; its busy is ignored until the controller returns to IDLE.
- BAUD/CFG writes:
  - Written into shadow registers with a pending flag.
  - Shadow is copied to baud_div/cfg on the first cycle where state=IDLE and FIFO is empty; the flag clears the same cycle.
  - If that condition already holds on the write cycle, the copy happens on the next edge (one-cycle latency).
  - BAUD/CFG reads return the shadow value.
- DATA write:
  - Not full: push with 1-cycle latency. Count and empty reflect the push next cycle.
  - Full with no pop that cycle: byte dropped, overflow set.
  - Full with a pop the same cycle: push accepted, count unchanged.
- STATUS write: wdata[3]=1 clears overflow. If a drop occurs in the same cycle, the set wins.
- FSM:
  - IDLE: if cfg[0]=1, FIFO not empty, tx_busy=0 and no shadow pending, go to LAUNCH.
    - Pending shadows with a non-empty FIFO wait until the FIFO drains; launches continue until then.
    - Clarification: the no-pending condition applies only when the FIFO is empty. With a non-empty FIFO, launches proceed using the old config.
  - LAUNCH (1 cycle): tx_start=1, tx_data=head; pop head; go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
  - Minimum inter-launch gap is therefore 3 cycles plus the frame time.
- cfg[0] cleared mid-frame: the current frame completes; no further launch.
- active = (state != IDLE).
- Pointers wrap modulo DEPTH. count ranges 0 to DEPTH.
- tx_data holds its last value when not launching.

Test Plan:
- Reset, then read STATUS -> 0x001 (empty), baud_div=0, cfg=0, tx_start=0.
- Write BAUD=0x38B0, CFG=0x01 with FIFO empty -> baud_div=0x38B0 and cfg=0x01 one cycle later; BAUD readback 0x38B0.
- Write DATA 0xB6, 0x42, 0x39 with a transmitter model busy 20 cycles per frame -> three tx_start pulses in FIFO order, each only after the prior busy falls. STATUS ends 0x001.
- With cfg[0]=0, write 9 bytes (DEPTH=8) -> count=8, full=1, overflow=1, ninth byte lost. Write STATUS 0x8 -> overflow=0.
- Write BAUD=0x0010 while 2 bytes are queued -> baud_div unchanged until the FIFO drains and state=IDLE, then becomes 0x0010.
- Assert rst during WAIT_DONE -> next cycle state IDLE, FIFO empty, tx_start=0; no launch while stale tx_busy=1.
